// File: rtl/pipelined_addsub.sv
// Segment-pipelined adder/subtractor with ready/valid flow control.
// One SEG-bit segment is added per stage; the segment carry is registered forward.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG;
  localparam int L    = NSEG - 1;

  logic             vld_q [NSEG];
  logic             vld_d [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic [WIDTH-1:0] res_d [NSEG];
  logic [WIDTH-1:0] xo_q  [NSEG];
  logic [WIDTH-1:0] xo_d  [NSEG];
  logic [WIDTH-1:0] yo_q  [NSEG];
  logic [WIDTH-1:0] yo_d  [NSEG];
  logic             cy_q  [NSEG];
  logic             cy_d  [NSEG];
  logic             cm_q;
  logic             cm_d;

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] ya;
  logic [SEG:0]     sa;

  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           c
  );
    return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
  endfunction

  always_comb begin
    advance = ~vld_q[L] | out_ready;
    accept  = in_valid & advance;
    vld_d   = vld_q;
    res_d   = res_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    cy_d    = cy_q;
    cm_d    = cm_q;
    ya      = y ^ {WIDTH{sub}};
    sa      = '0;

    if (advance) begin
      vld_d[0] = accept;
      if (accept) begin
        sa = seg_add(x[SEG-1:0], ya[SEG-1:0], cin ^ sub);
        xo_d[0]  = x;
        yo_d[0]  = ya;
        res_d[0] = '0;
        res_d[0][SEG-1:0] = sa[SEG-1:0];
        cy_d[0]  = sa[SEG];
        if (L == 0)
          cm_d = x[WIDTH-1] ^ ya[WIDTH-1] ^ sa[SEG-1];
      end

      for (int k = 1; k < NSEG; k++) begin
        vld_d[k] = vld_q[k-1];
        // data only moves with a real beat; bubbles leave it untouched
        if (vld_q[k-1]) begin
          sa = seg_add(xo_q[k-1][k*SEG +: SEG],
                       yo_q[k-1][k*SEG +: SEG],
                       cy_q[k-1]);
          xo_d[k]  = xo_q[k-1];
          yo_d[k]  = yo_q[k-1];
          res_d[k] = res_q[k-1];
          res_d[k][k*SEG +: SEG] = sa[SEG-1:0];
          cy_d[k]  = sa[SEG];
          if (k == L)
            cm_d = xo_q[k-1][WIDTH-1] ^ yo_q[k-1][WIDTH-1] ^ sa[SEG-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int k = 0; k < NSEG; k++) begin
        vld_q[k] <= 1'b0;
        res_q[k] <= '0;
        xo_q[k]  <= '0;
        yo_q[k]  <= '0;
        cy_q[k]  <= 1'b0;
      end
      cm_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      xo_q  <= xo_d;
      yo_q  <= yo_d;
      cy_q  <= cy_d;
      cm_q  <= cm_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[L];
  assign s         = res_q[L];
  assign cout      = cy_q[L];
  assign ovf       = cm_q ^ cy_q[L];
  assign zero      = ~|res_q[L];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed vector bench for pipelined_addsub in three
// width/segment configurations (32/16, 64/8, 16/16).
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n, in_valid, sub, cin, out_ready;
  logic [63:0] x, y;
  int          sel;

  logic iv0, iv1, iv2;
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  logic        rdy0, vo0, c0, ov0, z0;
  logic [31:0] s0;
  logic        rdy1, vo1, c1, ov1, z1;
  logic [63:0] s1;
  logic        rdy2, vo2, c2, ov2, z2;
  logic [15:0] s2;

  pipelined_addsub #(.WIDTH(32), .SEG(16)) u0 (
    .clk(clk), .clr_n(clr_n), .in_valid(iv0), .in_ready(rdy0),
    .sub(sub), .cin(cin), .x(x[31:0]), .y(y[31:0]),
    .out_valid(vo0), .out_ready(out_ready), .s(s0),
    .cout(c0), .ovf(ov0), .zero(z0));

  pipelined_addsub #(.WIDTH(64), .SEG(8)) u1 (
    .clk(clk), .clr_n(clr_n), .in_valid(iv1), .in_ready(rdy1),
    .sub(sub), .cin(cin), .x(x), .y(y),
    .out_valid(vo1), .out_ready(out_ready), .s(s1),
    .cout(c1), .ovf(ov1), .zero(z1));

  pipelined_addsub #(.WIDTH(16), .SEG(16)) u2 (
    .clk(clk), .clr_n(clr_n), .in_valid(iv2), .in_ready(rdy2),
    .sub(sub), .cin(cin), .x(x[15:0]), .y(y[15:0]),
    .out_valid(vo2), .out_ready(out_ready), .s(s2),
    .cout(c2), .ovf(ov2), .zero(z2));

  logic        o_valid, o_ready, o_c, o_ov, o_z;
  logic [63:0] o_s;

  always_comb begin
    o_valid = vo0; o_ready = rdy0; o_s = {32'b0, s0};
    o_c = c0; o_ov = ov0; o_z = z0;
    if (sel == 1) begin
      o_valid = vo1; o_ready = rdy1; o_s = s1;
      o_c = c1; o_ov = ov1; o_z = z1;
    end else if (sel == 2) begin
      o_valid = vo2; o_ready = rdy2; o_s = {48'b0, s2};
      o_c = c2; o_ov = ov2; o_z = z2;
    end
  end

  typedef struct {
    int          w;
    logic [63:0] x;
    logic [63:0] y;
    logic        sub;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];
  int   popc[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   wid[3] = '{32, 64, 16};
  int   nsg[3] = '{2, 8, 1};

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s sel=%0d: got %h want %h", nm, sel, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    vec_t e;
    if (clr_n === 1'b1 && o_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        check("out_valid_extra", o_valid, 0);
      end else begin
        e = expq.pop_front();
        check("s", o_s, e.s);
        check("cout", o_c, e.co);
        check("ovf", o_ov, e.ov);
        check("zero", o_z, e.z);
        popc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, output bit acc);
    x = v.x; y = v.y; sub = v.sub; cin = v.cin;
    in_valid = 1'b1;
    acc = o_ready;
    tick();
    in_valid = 1'b0;
    if (acc) expq.push_back(v);
  endtask

  task automatic drain();
    int b = 0;
    while (expq.size() != 0 && b < 60) begin
      tick();
      b++;
    end
    check("drained", expq.size(), 0);
  endtask

  task automatic rst_chk(input string nm);
    check({nm, "_valid"}, o_valid, 0);
    check({nm, "_s"}, o_s, 0);
    check({nm, "_cout"}, o_c, 0);
    check({nm, "_ovf"}, o_ov, 0);
    check({nm, "_zero"}, o_z, 1);
    check({nm, "_in_ready"}, o_ready, 1);
  endtask

  initial begin
    vec_t vs[$];
    vec_t snap;
    bit   acc;
    int   n, sent;

    tbl.push_back('{32, 64'h0000FFFF, 64'h1, 1'b0, 1'b1, 64'h00010001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{32, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{32, 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{32, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32, 64'h80000000, 64'h1, 1'b1, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{64, 64'h000000000000FFFF, 64'h1, 1'b0, 1'b1, 64'h0000000000010001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{64, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{64, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{64, 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{64, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16, 64'h00FF, 64'h1, 1'b0, 1'b1, 64'h0101, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 64'hFFFE, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{16, 64'h7FFF, 64'h1, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{16, 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{16, 64'h8000, 64'h1, 1'b1, 1'b0, 64'h7FFF, 1'b1, 1'b1, 1'b0});

    sel = 0; clr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; cin = 1'b0; x = '0; y = '0;
    repeat (2) tick();
    clr_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #0;
      rst_chk("reset");
    end

    for (int k = 0; k < 3; k++) begin
      sel = k;
      out_ready = 1'b1;
      vs.delete();
      foreach (tbl[i]) if (tbl[i].w == wid[k]) vs.push_back(tbl[i]);

      send(vs[0], acc);
      n = 1;
      while (!o_valid && n < 20) begin
        tick();
        n++;
      end
      check("latency", n, nsg[k]);
      drain();

      popc.delete();
      foreach (vs[i]) begin
        send(vs[i], acc);
        check("burst_accept", acc, 1);
      end
      drain();
      check("burst_count", popc.size(), vs.size());
      for (int i = 1; i < popc.size(); i++)
        check("burst_gap", popc[i] - popc[i-1], 1);

      out_ready = 1'b0;
      sent = 0;
      for (int i = 0; i < 3; i++) begin
        if (o_ready) begin
          send(vs[i+1], acc);
          sent++;
        end
        check("in_ready_vs_valid", o_ready, !o_valid);
      end
      check("stall_accepted", sent, (nsg[k] < 3) ? nsg[k] : 3);
      n = 0;
      while (!o_valid && n < 20) begin
        tick();
        n++;
      end
      snap.s = o_s; snap.co = o_c; snap.ov = o_ov; snap.z = o_z;
      repeat (4) begin
        tick();
        check("stall_valid", o_valid, 1);
        check("stall_in_ready", o_ready, 0);
        check("stall_s", o_s, snap.s);
        check("stall_flags", {o_c, o_ov, o_z}, {snap.co, snap.ov, snap.z});
      end
      out_ready = 1'b1;
      drain();
    end

    sel = 1;
    out_ready = 1'b1;
    send(tbl[6], acc);
    send(tbl[7], acc);
    expq.delete();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    rst_chk("midflight");
    repeat (12) tick();
    check("midflight_quiet", o_valid, 0);
    check("midflight_s", o_s, 0);

    sel = 0;
    x = 64'h1234; y = 64'h1; sub = 1'b0; cin = 1'b0;
    clr_n = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_n = 1'b1;
    repeat (4) begin
      tick();
      check("reset_drop_valid", o_valid, 0);
    end
    check("reset_drop_s", o_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
